// File: rtl/nexys_starship_fault_sched.sv
`timescale 1ns/1ps
// Fault scheduler: decides when/which repair subsystem breaks, ramps difficulty, ends game on unrepaired timeout.
// Latency: all outputs registered; break_req/random_hex appear one cycle after the PICK decision cycle.
// Backpressure: none; a new break is withheld while MAX_BROKEN or more subsystems are already broken.
module nexys_starship_fault_sched #(
   parameter int TICK_DIV         = 4,
   parameter int BASE_INTERVAL    = 10,
   parameter int MIN_INTERVAL     = 2,
   parameter int LEVEL_STEP       = 2,
   parameter int COOLDOWN_TICKS   = 3,
   parameter int TIMEOUT_TICKS    = 20,
   parameter int MAX_BROKEN       = 3,
   parameter int BREAKS_PER_LEVEL = 2
) (
   input  logic       Clk,
   input  logic       Reset_n,
   input  logic       play_flag,
   input  logic [3:0] broken,
   output logic [3:0] break_req,
   output logic [3:0] random_hex,
   output logic       gameover_ctrl,
   output logic [2:0] level,
   output logic       active
);

   localparam logic [4:0] S_IDLE  = 5'b00001;
   localparam logic [4:0] S_ARMED = 5'b00010;
   localparam logic [4:0] S_PICK  = 5'b00100;
   localparam logic [4:0] S_COOL  = 5'b01000;
   localparam logic [4:0] S_OVER  = 5'b10000;

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int WW = $clog2(TIMEOUT_TICKS + 1);
   localparam int CW = $clog2(COOLDOWN_TICKS + 1);
   localparam int BW = (BREAKS_PER_LEVEL > 1) ? $clog2(BREAKS_PER_LEVEL) : 1;

   localparam logic [10:0] BASE_I = 11'(BASE_INTERVAL);
   localparam logic [10:0] MIN_I  = 11'(MIN_INTERVAL);
   localparam logic [10:0] SPAN_I = 11'(BASE_INTERVAL - MIN_INTERVAL);

   logic [4:0]    state, nxt;
   logic [15:0]   lfsr;
   logic [PW-1:0] presc;
   logic          tick;
   logic          presc_clr;
   logic [10:0]   ivl_cnt;
   logic [10:0]   lvl_step, interval;
   logic [CW-1:0] cool_cnt;
   logic [BW-1:0] brk_cnt;
   logic [WW-1:0] wd_cnt [4];
   logic          wd_hit;
   logic          full;
   logic          pick_ok;
   logic [1:0]    pick_idx;

   function automatic logic is_busy(input logic [4:0] s);
      return (s == S_ARMED) || (s == S_PICK) || (s == S_COOL);
   endfunction

   // Interval shrinks with level, clamped at the floor; 11-bit math keeps the subtraction safe.
   assign lvl_step = 11'(level) * 11'(LEVEL_STEP);
   assign interval = (lvl_step >= SPAN_I) ? MIN_I : BASE_I - lvl_step;

   assign full      = ($countones(broken) >= MAX_BROKEN);
   assign presc_clr = !is_busy(nxt) || ((nxt == S_ARMED) && (state != S_ARMED));

   // Any subsystem left broken too long ends the game.
   always_comb begin
      wd_hit = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (wd_cnt[i] == WW'(TIMEOUT_TICKS)) wd_hit = 1'b1;
      end
   end

   // Random candidate, rotated forward to the first subsystem that is still healthy.
   always_comb begin
      pick_ok  = 1'b0;
      pick_idx = lfsr[1:0];
      for (int k = 3; k >= 0; k--) begin
         if (!broken[lfsr[1:0] + 2'(k)]) begin
            pick_ok  = 1'b1;
            pick_idx = lfsr[1:0] + 2'(k);
         end
      end
   end

   // Next-state: play_flag drop beats watchdog, watchdog beats a pending break.
   always_comb begin
      nxt = state;
      case (state)
         S_IDLE:  if (play_flag) nxt = S_ARMED;
         S_ARMED, S_PICK, S_COOL: begin
            if (!play_flag)  nxt = S_IDLE;
            else if (wd_hit) nxt = S_OVER;
            else if (state == S_ARMED) begin
               if (tick && (ivl_cnt == 11'd1)) nxt = S_PICK;
            end else if (state == S_PICK) begin
               nxt = (full || !pick_ok) ? S_ARMED : S_COOL;
            end else begin
               if (tick && (cool_cnt == CW'(COOLDOWN_TICKS - 1))) nxt = S_ARMED;
            end
         end
         S_OVER:  if (!play_flag) nxt = S_IDLE;
         default: nxt = S_IDLE;
      endcase
   end

   // Free-running LFSR so the break pattern depends on game timing.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) lfsr <= 16'hACE1;
      else          lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   end

   // Tick prescaler, restarted on every ARMED entry so intervals are exact.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         presc <= '0;
         tick  <= 1'b0;
      end else if (presc_clr) begin
         presc <= '0;
         tick  <= 1'b0;
      end else begin
         tick  <= (presc == PW'(TICK_DIV - 1));
         presc <= (presc == PW'(TICK_DIV - 1)) ? '0 : presc + PW'(1);
      end
   end

   // Per-subsystem watchdogs: count ticks while broken during play, saturate at the limit.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 4; i++) wd_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if ((state == S_IDLE) || !broken[i])
               wd_cnt[i] <= '0;
            else if (is_busy(state) && tick && (wd_cnt[i] != WW'(TIMEOUT_TICKS)))
               wd_cnt[i] <= wd_cnt[i] + WW'(1);
         end
      end
   end

   // Scheduler state, counters and registered outputs.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state         <= S_IDLE;
         ivl_cnt       <= '0;
         cool_cnt      <= '0;
         brk_cnt       <= '0;
         level         <= '0;
         break_req     <= '0;
         random_hex    <= '0;
         gameover_ctrl <= 1'b0;
         active        <= 1'b0;
      end else begin
         state         <= nxt;
         break_req     <= '0;
         gameover_ctrl <= (nxt == S_OVER) && (state != S_OVER);
         active        <= is_busy(nxt);
         case (state)
            S_IDLE: if (nxt == S_ARMED) begin
               level   <= '0;
               brk_cnt <= '0;
               ivl_cnt <= BASE_I;
            end
            S_ARMED: if ((nxt == S_ARMED) && tick) ivl_cnt <= ivl_cnt - 11'd1;
            S_PICK: begin
               if (nxt == S_COOL) begin
                  break_req  <= 4'b0001 << pick_idx;
                  random_hex <= lfsr[7:4];
                  cool_cnt   <= '0;
                  if (brk_cnt == BW'(BREAKS_PER_LEVEL - 1)) begin
                     brk_cnt <= '0;
                     if (level != 3'd7) level <= level + 3'd1;
                  end else begin
                     brk_cnt <= brk_cnt + BW'(1);
                  end
               end else if (nxt == S_ARMED) begin
                  ivl_cnt <= interval;
               end
            end
            S_COOL: begin
               if (nxt == S_ARMED) ivl_cnt  <= interval;
               else if (tick)      cool_cnt <= cool_cnt + CW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule
